// File: rtl/lzc_pkg.sv
// rtl/lzc_pkg.sv - shared types, mode encodings and count-width helper for the leading-run counter
package lzc_pkg;

    // Wide enough for the count of a 64-bit padded group (0..64).
    localparam int LZC_CNT_MAX_W = 7;

    localparam logic LZC_MODE_ZEROS = 1'b0;
    localparam logic LZC_MODE_ONES  = 1'b1;

    typedef struct packed {
        logic [LZC_CNT_MAX_W-1:0] count;
        logic                     all;
    } lzc_grp_t;

    function automatic int lzc_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/lzc_merge.sv
// rtl/lzc_merge.sv - merges two adjacent equal-size group results into one of twice the size
module lzc_merge #(
    parameter int CW = 1
) (
    input  logic [CW-1:0] hi_count,
    input  logic          hi_all,
    input  logic [CW-1:0] lo_count,
    input  logic          lo_all,
    output logic [CW:0]   count,
    output logic          all
);

    assign all = hi_all & lo_all;

    // A fully matching upper half lets the run continue into the lower half.
    assign count = hi_all ? ({1'b0, hi_count} + {1'b0, lo_count}) : {1'b0, hi_count};

endmodule

// File: rtl/lzc_norm_pipe.sv
// rtl/lzc_norm_pipe.sv - pipelined leading zero/one counter; normalizer built only with LZC_NORM_SHIFT_EN
// Tree levels and the shifter are spread over STAGES registers sharing a single stall signal.
module lzc_norm_pipe
    import lzc_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int STAGES = 2,
    localparam int CNT_W = lzc_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm
);

    localparam int LVLS = $clog2(WIDTH);
    localparam int PW   = 1 << LVLS;
`ifdef LZC_NORM_SHIFT_EN
    localparam int NREAL = LVLS + 1;
`else
    localparam int NREAL = LVLS;
`endif
    localparam int NOPS = (NREAL > STAGES) ? NREAL : STAGES;

    typedef struct packed {
        logic              valid;
        logic              mode;
        logic [WIDTH-1:0]  operand;
        lzc_grp_t [PW-1:0] grp;
    } node_t;

    function automatic int stage_of(input int op);
        return (op * STAGES) / NOPS;
    endfunction

    logic  advance;
    node_t head;
    node_t last;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Pad slots below the operand LSB never match, which caps the count at WIDTH.
    always_comb begin
        head       = '0;
        head.valid = in_valid;
        head.mode  = in_mode;
`ifdef LZC_NORM_SHIFT_EN
        head.operand = in_data;
`endif
        for (int i = PW - WIDTH; i < PW; i++) begin
            head.grp[i].count = LZC_CNT_MAX_W'(in_data[i - (PW - WIDTH)] == in_mode);
            head.grp[i].all   = (in_data[i - (PW - WIDTH)] == in_mode);
        end
    end

    for (genvar j = 0; j < NOPS; j++) begin : g_op
        node_t src;
        node_t res;
        node_t q;

        if (j == 0) begin : g_first
            assign src = head;
        end else begin : g_chain
            assign src = g_op[j-1].q;
        end

        if (j < LVLS) begin : g_merge
            localparam int NG = PW >> (j + 1);
            logic [NG-1:0][j+1:0] cnt;
            logic [NG-1:0]        all;

            for (genvar i = 0; i < NG; i++) begin : g_pair
                lzc_merge #(.CW(j + 1)) u_merge (
                    .hi_count(src.grp[2*i+1].count[j:0]),
                    .hi_all  (src.grp[2*i+1].all),
                    .lo_count(src.grp[2*i].count[j:0]),
                    .lo_all  (src.grp[2*i].all),
                    .count   (cnt[i]),
                    .all     (all[i])
                );
            end

            always_comb begin
                res     = src;
                res.grp = '0;
                for (int i = 0; i < NG; i++) begin
                    res.grp[i].count = LZC_CNT_MAX_W'(cnt[i]);
                    res.grp[i].all   = all[i];
                end
            end
        end
`ifdef LZC_NORM_SHIFT_EN
        else if (j == LVLS) begin : g_shift
            // Shift by WIDTH yields zero, covering the all-match case directly.
            always_comb begin
                res         = src;
                res.operand = src.operand << src.grp[0].count;
            end
        end
`endif
        else begin : g_pass
            assign res = src;
        end

        if (j == NOPS - 1 || stage_of(j) != stage_of(j + 1)) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (advance) begin
                    q <= res;
                end
            end
        end else begin : g_wire
            assign q = res;
        end
    end

    assign last      = g_op[NOPS-1].q;
    assign out_valid = last.valid;
    assign out_count = last.grp[0].count[CNT_W-1:0];
    assign out_zero  = last.valid && (last.grp[0].count == LZC_CNT_MAX_W'(WIDTH));
    assign out_norm  = last.operand;

endmodule

// File: doc/lzc_norm_pipe.md
LZC_NORM_PIPE -- requirements
Module: lzc_norm_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 24: operand width, legal range 8..64.
REQ-002 SHALL have parameter STAGES, default 2: register stages from input to output, legal range 1..4.
REQ-003 SHALL have derived localparam CNT_W = clog2(WIDTH+1): count width, 5 for WIDTH=24.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: operand present.
REQ-007 SHALL have port in_ready, output, 1 bit: operand accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data, input, WIDTH bits: operand, MSB first.
REQ-009 SHALL have port in_mode, input, 1 bit: 0 = count leading zeros, 1 = count leading ones.
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes the result when out_valid && out_ready.
REQ-012 SHALL have port out_count, output, CNT_W bits: leading-run length.
REQ-013 SHALL have port out_zero, output, 1 bit: the whole operand equals the counted symbol.
REQ-014 SHALL have port out_norm, output, WIDTH bits: operand shifted left by out_count, zero-filled.

Function
REQ-015 SHALL compute out_count as the number of consecutive bits equal to in_mode, starting from in_data[WIDTH-1].
REQ-016 SHALL, when every bit equals the counted symbol, give out_count=WIDTH, out_zero=1 and out_norm=0; otherwise out_zero=0.
REQ-017 SHALL use a log2-depth tree of group detectors (grouped count plus all-match flag, merged pairwise) and no linear priority scan.
REQ-018 SHALL divide the tree levels and the normalize shifter evenly across STAGES register stages; each stage carries a valid bit, the operand, the mode and partial results.
REQ-019 SHALL assert out_valid exactly STAGES cycles after acceptance when out_ready is held high.
REQ-020 SHALL sustain one result per cycle when out_ready is held high.
REQ-021 SHALL compute advance = !out_valid || out_ready; all stages shift only on advance; in_ready = advance.
REQ-022 SHALL hold out_count, out_zero and out_norm stable while out_valid=1 and out_ready=0.
REQ-023 SHALL have a capacity of STAGES results; with out_ready low, in_ready falls once the last stage holds valid data.
REQ-024 SHALL, when accepting and emitting in the same cycle, do both with no bubble and no loss.
REQ-025 SHALL make in_ready depend on out_valid and out_ready only, never on in_valid.

Reset
REQ-026 SHALL, while rst_n=0, clear all stage valid bits at once, so out_valid=0, out_count=0, out_zero=0 and out_norm=0.
REQ-027 SHALL discard any in-flight operands on a reset mid-operation; none SHALL appear after release.
REQ-028 SHALL make in_ready=1 in the first cycle after reset release.

Configuration
REQ-029 SHALL include the normalize shifter only when macro LZC_NORM_SHIFT_EN is defined; then out_norm SHALL follow REQ-014.
REQ-030 SHALL, when LZC_NORM_SHIFT_EN is undefined, tie out_norm to 0 and carry no operand bits past the count logic; count, zero flag, latency and handshake SHALL be unchanged.

Structure
REQ-031 SHALL place the following in shared package lzc_pkg: the clog2-based count-width function, the mode encoding constants (LZC_MODE_ZEROS=0, LZC_MODE_ONES=1) and the group-result struct (count, all-match flag).
REQ-032 SHALL implement the pairwise merge as one sub-module, lzc_merge, parametrised by input count width; it outputs the merged count and all-match flag.
REQ-033 SHALL implement the pipeline registers and handshake in lzc_norm_pipe itself.

Verification (WIDTH=24, STAGES=2, LZC_NORM_SHIFT_EN defined unless stated)
REQ-034 SHALL check: in_data=0x800000, mode 0 -> count 0, zero 0, norm 0x800000, out_valid 2 cycles after acceptance.
REQ-035 SHALL check: in_data=0x000001, mode 0 -> count 23, norm 0x800000; in_data=0x000000 -> count 24, zero 1, norm 0.
REQ-036 SHALL check: in_data=0xFF0F00, mode 1 -> count 8, norm 0x0F0000; in_data=0xFFFFFF, mode 1 -> count 24, zero 1.
REQ-037 SHALL check: out_ready low for 6 cycles while in_valid streams 0x400000, 0x200000, 0x100000 -> in_ready low after 2 acceptances; on out_ready rise, counts 1, 2, 3 emerge in order, outputs stable while stalled, none lost or duplicated.
REQ-038 SHALL check: rst_n pulsed low with 2 operands in flight -> out_valid low at once and no stale result after release.
REQ-039 SHALL check: 1000 random operands, random modes and random out_ready with the macro undefined -> counts match the reference model, out_norm always 0.
